instruction_fetch: RTL and testbench



---
 rtl/protocore_pkg.sv | 11 +
 rtl/fetch_buffer.sv | 58 +++++
 rtl/instruction_fetch.sv | 57 +++++
 tb/tb_instruction_fetch.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/protocore_pkg.sv
// protocore_pkg: shared widths, reset PC and fetch-stage types
package protocore_pkg;
    localparam int ADDR_W = 8;
    localparam int INSTR_W = 24;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    typedef enum logic {IDLE, RUN} fetch_state_e;
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry in-order output/skid buffer with valid/ready and synchronous flush
module fetch_buffer
    import protocore_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic               skid_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);
    fetch_entry_t out_q, out_d, skid_q, skid_d, in_e;
    logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, fire;
    always_comb begin
        fire = out_valid_q & out_ready;
        in_e = '{instr: in_instr, pc: in_pc};
        out_d = out_q;
        skid_d = skid_q;
        out_valid_d = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (fire && skid_valid_q) begin
            out_d = skid_q;
            skid_valid_d = in_valid;
            skid_d = in_valid ? in_e : skid_q;
        end else if (!out_valid_q || fire) begin
            out_valid_d = in_valid;
            out_d = in_valid ? in_e : out_q;
        end else if (in_valid) begin
            skid_valid_d = 1'b1;
            skid_d = in_e;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            skid_q <= '0;
            out_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q <= out_d;
            skid_q <= skid_d;
            out_valid_q <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
    assign out_valid = out_valid_q;
    assign skid_valid = skid_valid_q;
    assign out_instr = out_q.instr;
    assign out_pc = out_q.pc;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, run/idle FSM and read issue for the instruction RAM
module instruction_fetch
    import protocore_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);
    fetch_state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pending_pc_q, pending_pc_d;
    logic pending_q, pending_d, skid_valid, issue;
    logic [1:0] occupancy;
    // issue only while the buffer can still absorb this read's response
    always_comb begin
        occupancy = 2'(instr_valid) + 2'(skid_valid) + 2'(pending_q) - 2'(instr_valid & instr_ready);
        issue = (state_q == RUN) && run && !redirect_valid && (occupancy <= 2'd1);
        state_d = run ? RUN : IDLE;
        pending_d = issue;
        pending_pc_d = issue ? pc_q : pending_pc_q;
        pc_d = redirect_valid ? redirect_pc : issue ? pc_q + ADDR_W'(1) : pc_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q <= RESET_PC;
            pending_q <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            pending_q <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end
    assign imem_addr = pc_q;
    fetch_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .in_valid  (pending_q),
        .in_instr  (imem_rdata),
        .in_pc     (pending_pc_q),
        .out_ready (instr_ready),
        .out_valid (instr_valid),
        .skid_valid(skid_valid),
        .out_instr (instr),
        .out_pc    (instr_pc)
    );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench; decode must see consecutive addresses from each reset/redirect target
module tb_instruction_fetch;
    import protocore_pkg::*;
    logic clk = 0, rst_n = 0, run = 0, redirect_valid = 0, instr_ready = 0;
    logic [ADDR_W-1:0] redirect_pc = '0, imem_addr, instr_pc;
    logic [INSTR_W-1:0] imem_rdata = '0, instr;
    logic instr_valid;
    logic [INSTR_W-1:0] mem [256];
    int errors = 0, checks = 0, nfire = 0;
    typedef struct packed {logic [ADDR_W-1:0] pc; logic [INSTR_W-1:0] w;} exp_t;
    exp_t sb[$];

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .run(run), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // expected program stream: consecutive addresses starting at the given target
    task automatic seg(input logic [ADDR_W-1:0] start);
        logic [ADDR_W-1:0] a;
        sb.delete();
        for (int i = 0; i < 600; i++) begin
            a = start + ADDR_W'(i);
            sb.push_back('{pc: a, w: 24'(int'(a) * 3)});
        end
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!instr_valid && k < 10) begin
            step;
            k++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && instr_valid && instr_ready) begin
            nfire++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual_pc=%0h required=none", instr_pc);
            end else begin
                e = sb.pop_front();
                chk("instr_pc", 32'(instr_pc), 32'(e.pc));
                chk("instr", 32'(instr), 32'(e.w));
            end
        end
    end

    initial begin
        int k, f0;
        logic [ADDR_W-1:0] ipc, ia, a;
        logic [INSTR_W-1:0] iw;
        logic r;
        for (int i = 0; i < 256; i++) mem[i] = 24'(i * 3);
        #1;
        chk("reset_valid", 32'(instr_valid), 0);
        chk("reset_addr", 32'(imem_addr), 32'(RESET_PC));
        chk("reset_instr_pc", 32'(instr_pc), 0);
        step; step;
        rst_n = 1;
        seg(RESET_PC);
        step;
        run = 1; instr_ready = 1;
        wait_valid(k);
        chk("first_latency", k, 3);
        chk("first_pc", 32'(instr_pc), 32'(RESET_PC));
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 32'(instr_valid), 1);
            step;
        end
        // backpressure
        instr_ready = 0;
        ipc = instr_pc; iw = instr; ia = imem_addr;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("bp_valid", 32'(instr_valid), 1);
            chk("bp_pc_hold", 32'(instr_pc), 32'(ipc));
            chk("bp_instr_hold", 32'(instr), 32'(iw));
            chk("bp_addr_hold", 32'(imem_addr), 32'(ia));
        end
        instr_ready = 1;
        for (int i = 0; i < 6; i++) begin
            chk("release_no_gap", 32'(instr_valid), 1);
            step;
        end
        // redirect while two instructions are buffered
        instr_ready = 0;
        step; step; step;
        redirect_valid = 1; redirect_pc = 8'h40;
        step;
        redirect_valid = 0; instr_ready = 1;
        seg(8'h40);
        chk("redirect_flush", 32'(instr_valid), 0);
        wait_valid(k);
        chk("redirect_latency", k + 1, 3);
        chk("redirect_pc", 32'(instr_pc), 32'h40);
        step; step; step;
        // redirect near the top of the address space
        redirect_valid = 1; redirect_pc = 8'hFE;
        step;
        redirect_valid = 0;
        seg(8'hFE);
        wait_valid(k);
        chk("wrap_first", 32'(instr_pc), 32'hFE);
        step; step;
        chk("wrap_zero", 32'(instr_pc), 32'h00);
        step; step; step;
        // run dropped with one pending and one presented
        run = 0;
        f0 = nfire;
        step; step; step; step; step;
        chk("drain_count", nfire - f0, 2);
        chk("drain_idle", 32'(instr_valid), 0);
        a = imem_addr;
        step; step;
        chk("idle_addr_stable", 32'(imem_addr), 32'(a));
        // randomized traffic
        run = 1;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 19) == 0);
            redirect_valid = r;
            redirect_pc = ADDR_W'($urandom);
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) run = ~run;
            a = redirect_pc;
            step;
            if (r) seg(a);
        end
        redirect_valid = 0; run = 1; instr_ready = 1;
        for (int i = 0; i < 6; i++) step;
        chk("pre_reset_stream", 32'(instr_valid), 1);
        // asynchronous reset mid-stream
        #2 rst_n = 0;
        #1;
        chk("async_valid", 32'(instr_valid), 0);
        chk("async_addr", 32'(imem_addr), 32'(RESET_PC));
        step;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
